// File: rtl/screens_flow_controller_pkg.sv
// Shared screen-flow definitions: state encoding, parameter defaults and a
// saturating counter helper.
package screens_flow_controller_pkg;

    typedef enum logic [2:0] {
        WELCOME       = 3'd0,
        TRANS_TO_PLAY = 3'd1,
        PLAYING       = 3'd2,
        END_HOLD      = 3'd3,
        END           = 3'd4
    } SCREEN_STATE;

    localparam int          DEF_TRANSITION_FRAMES = 30;
    localparam logic [15:0] DEF_WIN_SCORE         = 16'd100;
    localparam int          DEF_END_HOLD_FRAMES   = 120;

    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/screens_flow_controller_key_edge_detector.sv
// Registered rising-edge pulse for a level key input. The first cycle after
// reset only samples the key, so a key held through reset never fires.
module key_edge_detector (
    input  logic clk,
    input  logic resetN,
    input  logic key,
    output logic rise
);

    logic armed;
    logic prev;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            armed <= 1'b0;
            prev  <= 1'b0;
            rise  <= 1'b0;
        end else begin
            armed <= 1'b1;
            prev  <= key;
            rise  <= armed & key & ~prev;
        end
    end

endmodule

// File: rtl/screens_flow_controller.sv
// Game-flow sequencer: welcome -> black transition -> play -> end screens,
// with start pulse, flipper selection, win/loss flag and session high score.
module screens_flow_controller
    import screens_flow_controller_pkg::*;
#(
    parameter int          TRANSITION_FRAMES = DEF_TRANSITION_FRAMES,
    parameter logic [15:0] WIN_SCORE         = DEF_WIN_SCORE,
    parameter int          END_HOLD_FRAMES   = DEF_END_HOLD_FRAMES
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        key4IsPressed,
    input  logic        key5IsPressed,
    input  logic        key6IsPressed,
    input  logic [3:0]  life,
    input  logic [15:0] score,
    input  logic [7:0]  RGB_screen_welcome,
    input  logic [7:0]  RGB_screen_main,
    input  logic [7:0]  RGB_screen_end,
    output logic [7:0]  RGB_screens,
    output logic        start,
    output logic        flipperType,
    output logic        gameWon,
    output logic [15:0] highScore,
    output logic [2:0]  screenState
);

    localparam logic [7:0] TRANS_LAST = 8'(TRANSITION_FRAMES - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(END_HOLD_FRAMES - 1);

    SCREEN_STATE state;
    logic [7:0]  frame_cnt;
    logic        over_armed;
    logic        key4_rise;
    logic        key5_rise;
    logic        key6_rise;
    logic        game_over;
    logic        win_now;
    logic [7:0]  rgb_next;

    key_edge_detector u_key4 (.clk(clk), .resetN(resetN), .key(key4IsPressed), .rise(key4_rise));
    key_edge_detector u_key5 (.clk(clk), .resetN(resetN), .key(key5IsPressed), .rise(key5_rise));
    key_edge_detector u_key6 (.clk(clk), .resetN(resetN), .key(key6IsPressed), .rise(key6_rise));

    assign screenState = state;
    assign win_now     = (score >= WIN_SCORE);
    // A win takes priority when lives run out on the same cycle.
    assign game_over   = over_armed && ((life == 4'd0) || win_now);

    always_comb begin
        rgb_next = 8'h00;
        case (state)
            WELCOME:       rgb_next = RGB_screen_welcome;
            TRANS_TO_PLAY: rgb_next = 8'h00;
            PLAYING:       rgb_next = RGB_screen_main;
            END_HOLD, END: rgb_next = RGB_screen_end;
            default:       rgb_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= WELCOME;
            frame_cnt   <= 8'd0;
            over_armed  <= 1'b0;
            RGB_screens <= 8'h00;
            start       <= 1'b0;
            flipperType <= 1'b0;
            gameWon     <= 1'b0;
            highScore   <= 16'd0;
        end else begin
            RGB_screens <= rgb_next;
            start       <= 1'b0;
            case (state)
                WELCOME: begin
                    if (key4_rise) flipperType <= 1'b0;
                    if (key6_rise) flipperType <= 1'b1;
                    if (key5_rise) begin
                        state     <= TRANS_TO_PLAY;
                        frame_cnt <= 8'd0;
                    end
                end
                TRANS_TO_PLAY: begin
                    if (startOfFrame) begin
                        if (frame_cnt == TRANS_LAST) begin
                            state      <= PLAYING;
                            start      <= 1'b1;
                            over_armed <= 1'b0;
                        end else begin
                            frame_cnt <= sat_inc(frame_cnt);
                        end
                    end
                end
                PLAYING: begin
                    // The main screen needs one frame after start before its
                    // life/score values describe the new game.
                    if (game_over) begin
                        state     <= END_HOLD;
                        gameWon   <= win_now;
                        frame_cnt <= 8'd0;
                        if (score > highScore) highScore <= score;
                    end else if (startOfFrame) begin
                        over_armed <= 1'b1;
                    end
                end
                END_HOLD: begin
                    if (startOfFrame) begin
                        if (frame_cnt == HOLD_LAST) state <= END;
                        else frame_cnt <= sat_inc(frame_cnt);
                    end
                end
                END: begin
                    if (key5_rise) state <= WELCOME;
                end
                default: state <= WELCOME;
            endcase
        end
    end

endmodule

// File: tb/tb_screens_flow_controller.sv
// Directed bench for screens_flow_controller: walks several games through all
// screens and checks outputs against hand-computed values.
module tb_screens_flow_controller;

    logic        clk = 1'b0;
    logic        resetN;
    logic        startOfFrame;
    logic        key4IsPressed;
    logic        key5IsPressed;
    logic        key6IsPressed;
    logic [3:0]  life;
    logic [15:0] score;
    logic [7:0]  RGB_screen_welcome;
    logic [7:0]  RGB_screen_main;
    logic [7:0]  RGB_screen_end;
    logic [7:0]  RGB_screens;
    logic        start;
    logic        flipperType;
    logic        gameWon;
    logic [15:0] highScore;
    logic [2:0]  screenState;

    int n_cmp = 0;
    int n_err = 0;

    screens_flow_controller dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .key4IsPressed(key4IsPressed), .key5IsPressed(key5IsPressed),
        .key6IsPressed(key6IsPressed), .life(life), .score(score),
        .RGB_screen_welcome(RGB_screen_welcome), .RGB_screen_main(RGB_screen_main),
        .RGB_screen_end(RGB_screen_end), .RGB_screens(RGB_screens), .start(start),
        .flipperType(flipperType), .gameWon(gameWon), .highScore(highScore),
        .screenState(screenState)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            startOfFrame = 1'b1;
            step();
            startOfFrame = 1'b0;
        end
    endtask

    // Holds the key for two edges (edge register + state register), then releases.
    task automatic press(input int k);
        if (k == 4) key4IsPressed = 1'b1;
        if (k == 5) key5IsPressed = 1'b1;
        if (k == 6) key6IsPressed = 1'b1;
        step();
        step();
        key4IsPressed = 1'b0;
        key5IsPressed = 1'b0;
        key6IsPressed = 1'b0;
        step();
    endtask

    task automatic play_to_playing();
        life  = 4'd3;
        score = 16'd0;
        press(5);
        frames(30);
        chk("enter_play_state", 16'(screenState), 16'd2);
    endtask

    task automatic end_game(input logic [15:0] s, input logic [3:0] l,
                            input logic exp_won, input logic [15:0] exp_hs);
        score = s;
        life  = l;
        frames(1);
        step();
        chk("end_hold_state", 16'(screenState), 16'd3);
        chk("game_won", 16'(gameWon), 16'(exp_won));
        chk("high_score", highScore, exp_hs);
    endtask

    task automatic leave_end();
        frames(120);
        chk("end_state", 16'(screenState), 16'd4);
        press(5);
        chk("back_to_welcome", 16'(screenState), 16'd0);
    endtask

    initial begin
        resetN = 1'b0;
        startOfFrame = 1'b0;
        key4IsPressed = 1'b0;
        key5IsPressed = 1'b1;
        key6IsPressed = 1'b0;
        life = 4'd3;
        score = 16'd0;
        RGB_screen_welcome = 8'h5A;
        RGB_screen_main = 8'hA5;
        RGB_screen_end = 8'hE7;
        step();
        step();
        chk("rst_state", 16'(screenState), 16'd0);
        chk("rst_rgb", 16'(RGB_screens), 16'h00);
        chk("rst_start", 16'(start), 16'd0);
        chk("rst_flipper", 16'(flipperType), 16'd0);
        chk("rst_high_score", highScore, 16'd0);

        // key5 held through reset release must not start a game
        resetN = 1'b1;
        step();
        step();
        step();
        step();
        chk("held_key5_no_start", 16'(screenState), 16'd0);
        key5IsPressed = 1'b0;
        step();

        chk("rgb_welcome", 16'(RGB_screens), 16'h5A);
        RGB_screen_welcome = 8'h3C;
        chk("rgb_welcome_lag", 16'(RGB_screens), 16'h5A);
        step();
        chk("rgb_welcome_new", 16'(RGB_screens), 16'h3C);

        press(6);
        chk("flip_key6", 16'(flipperType), 16'd1);
        press(4);
        chk("flip_key4", 16'(flipperType), 16'd0);
        press(6);
        chk("flip_key6_again", 16'(flipperType), 16'd1);

        press(5);
        chk("trans_state", 16'(screenState), 16'd1);
        chk("trans_rgb_black", 16'(RGB_screens), 16'h00);
        frames(29);
        chk("trans_after_29", 16'(screenState), 16'd1);
        chk("no_start_in_trans", 16'(start), 16'd0);
        frames(1);
        chk("play_after_30", 16'(screenState), 16'd2);
        chk("start_pulse", 16'(start), 16'd1);
        step();
        chk("start_one_cycle", 16'(start), 16'd0);
        chk("rgb_main", 16'(RGB_screens), 16'hA5);

        press(4);
        chk("flip_kept_key4_play", 16'(flipperType), 16'd1);
        press(6);
        chk("flip_kept_key6_play", 16'(flipperType), 16'd1);
        chk("still_playing", 16'(screenState), 16'd2);

        // Not armed yet: no frame since start
        life = 4'd0;
        step();
        step();
        step();
        chk("unarmed_no_end", 16'(screenState), 16'd2);
        end_game(16'd42, 4'd0, 1'b0, 16'd42);
        step();
        chk("rgb_end", 16'(RGB_screens), 16'hE7);

        frames(60);
        press(5);
        chk("key5_ignored_hold", 16'(screenState), 16'd3);
        frames(59);
        chk("hold_after_119", 16'(screenState), 16'd3);
        frames(1);
        chk("end_after_120", 16'(screenState), 16'd4);
        press(5);
        chk("welcome_again", 16'(screenState), 16'd0);
        chk("flip_retained", 16'(flipperType), 16'd1);

        play_to_playing();
        end_game(16'd30, 4'd0, 1'b0, 16'd42);
        leave_end();

        play_to_playing();
        end_game(16'd57, 4'd0, 1'b0, 16'd57);
        leave_end();

        play_to_playing();
        end_game(16'd100, 4'd0, 1'b1, 16'd100);
        leave_end();

        // Asynchronous reset mid-game
        play_to_playing();
        step();
        chk("pre_reset_rgb", 16'(RGB_screens), 16'hA5);
        resetN = 1'b0;
        #1;
        chk("async_rst_state", 16'(screenState), 16'd0);
        chk("async_rst_rgb", 16'(RGB_screens), 16'h00);
        chk("async_rst_flipper", 16'(flipperType), 16'd0);
        chk("async_rst_won", 16'(gameWon), 16'd0);
        chk("async_rst_high", highScore, 16'd0);
        chk("async_rst_start", 16'(start), 16'd0);
        step();
        resetN = 1'b1;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
